// File: rtl/zoom_cmd_scheduler.sv
// Command scheduler between the HPS decoder and the zoom FSM. Commands are queued
// in a small FIFO and issued one at a time, waiting for accept and completion.
module zoom_cmd_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int DONE_TIMEOUT = 2000000
) (
  input  logic       CLOCK_50,
  input  logic       internal_power_on_reset,
  input  logic       sw_flush,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  input  logic [1:0] cmd_alg,
  output logic       cmd_ready,
  output logic       ctrl_zoom_in,
  output logic       ctrl_zoom_out,
  output logic       ctrl_return,
  output logic [1:0] ctrl_alg_select,
  input  logic       ctrl_busy,
  input  logic       ctrl_done,
  input  logic       ctrl_invalid_zoom,
  output logic       sched_busy,
  output logic [2:0] fifo_count,
  output logic [7:0] done_count,
  output logic [3:0] err_flags
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int ATW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int DTW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam int TW  = (ATW > DTW) ? ATW : DTW;

  localparam logic [2:0] C_ZOOM_IN  = 3'd1;
  localparam logic [2:0] C_ZOOM_OUT = 3'd2;
  localparam logic [2:0] C_RETURN   = 3'd3;
  localparam logic [2:0] C_SET_ALG  = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [2:0]      op_code_reg;
  logic [1:0]      op_alg_reg;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [1:0]      alg_reg;
  logic [7:0]      done_reg;
  logic [3:0]      err_reg;
  logic            inv_prev_reg;
  logic            code_legal, push, pop;
  logic            alg_load, done_inc, ack_to, done_to;

  assign code_legal = (cmd_code != 3'd0) && (cmd_code <= C_SET_ALG);
  assign cmd_ready  = (count_reg != CW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready & code_legal & ~sw_flush;
  assign pop        = (state_reg == IDLE) && (count_reg != '0) && !sw_flush;

  assign ctrl_alg_select = alg_reg;
  assign sched_busy      = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count      = 3'(count_reg);
  assign done_count      = done_reg;
  assign err_flags       = err_reg;

  // Queue storage behaves like a RAM: write port on push, registered read on pop.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr_reg] <= {cmd_code, cmd_alg};
    if (pop) {op_code_reg, op_alg_reg} <= mem[rd_ptr_reg];
  end

  // Pulses decode only registered state, so ctrl_* inputs never reach them.
  always_comb begin
    state_next    = state_reg;
    timer_next    = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;
    alg_load      = 1'b0;
    done_inc      = 1'b0;
    ack_to        = 1'b0;
    done_to       = 1'b0;
    ctrl_zoom_in  = 1'b0;
    ctrl_zoom_out = 1'b0;
    ctrl_return   = 1'b0;
    case (state_reg)
      IDLE: if (pop) state_next = ISSUE;
      ISSUE: begin
        timer_next = '0;
        if (op_code_reg == C_SET_ALG) begin
          alg_load   = 1'b1;
          done_inc   = 1'b1;
          state_next = IDLE;
        end else begin
          ctrl_zoom_in  = (op_code_reg == C_ZOOM_IN);
          ctrl_zoom_out = (op_code_reg == C_ZOOM_OUT);
          ctrl_return   = (op_code_reg == C_RETURN);
          state_next    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ctrl_busy) begin
          state_next = WAIT_DONE;
          timer_next = '0;
        end else if (ctrl_invalid_zoom && (!inv_prev_reg || timer_reg == '0)) begin
          state_next = IDLE;
        end else if (ctrl_done) begin
          done_inc   = 1'b1;
          state_next = IDLE;
        end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
          ack_to     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (ctrl_done) begin
          done_inc   = 1'b1;
          state_next = IDLE;
        end else if (timer_reg == TW'(DONE_TIMEOUT - 1)) begin
          done_to    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (sw_flush) state_next = IDLE;
  end

  always_ff @(posedge CLOCK_50 or posedge internal_power_on_reset) begin
    if (internal_power_on_reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      inv_prev_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      alg_reg      <= 2'b00;
      done_reg     <= 8'd0;
      err_reg      <= 4'd0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      inv_prev_reg <= ctrl_invalid_zoom;
      if (sw_flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        done_reg   <= 8'd0;
        err_reg    <= 4'd0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
        if (alg_load) alg_reg  <= op_alg_reg;
        if (done_inc) done_reg <= done_reg + 8'd1;
        err_reg <= err_reg | {done_to, ack_to,
                              cmd_valid & (cmd_code > C_SET_ALG),
                              cmd_valid & ~cmd_ready};
      end
    end
  end

endmodule

// File: tb/tb_zoom_cmd_scheduler.sv
// Directed bench for zoom_cmd_scheduler: hand-timed vectors, one line per miscompare.
module tb_zoom_cmd_scheduler;

  logic       CLOCK_50;
  logic       internal_power_on_reset;
  logic       sw_flush, cmd_valid;
  logic [2:0] cmd_code;
  logic [1:0] cmd_alg;
  logic       cmd_ready, ctrl_zoom_in, ctrl_zoom_out, ctrl_return;
  logic [1:0] ctrl_alg_select;
  logic       ctrl_busy, ctrl_done, ctrl_invalid_zoom;
  logic       sched_busy;
  logic [2:0] fifo_count;
  logic [7:0] done_count;
  logic [3:0] err_flags;

  int vectors = 0;
  int miscompares = 0;
  int n_zin = 0, n_zout = 0;
  int z0;

  localparam logic [21:0] RESET_SNAP = 22'h200000;

  zoom_cmd_scheduler dut (
    .CLOCK_50(CLOCK_50), .internal_power_on_reset(internal_power_on_reset),
    .sw_flush(sw_flush), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_alg(cmd_alg),
    .cmd_ready(cmd_ready), .ctrl_zoom_in(ctrl_zoom_in), .ctrl_zoom_out(ctrl_zoom_out),
    .ctrl_return(ctrl_return), .ctrl_alg_select(ctrl_alg_select), .ctrl_busy(ctrl_busy),
    .ctrl_done(ctrl_done), .ctrl_invalid_zoom(ctrl_invalid_zoom), .sched_busy(sched_busy),
    .fifo_count(fifo_count), .done_count(done_count), .err_flags(err_flags)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (ctrl_zoom_in)  n_zin++;
    if (ctrl_zoom_out) n_zout++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [1:0] a);
    cmd_valid = 1'b1; cmd_code = c; cmd_alg = a;
    tick();
    cmd_valid = 1'b0; cmd_code = 3'd0; cmd_alg = 2'd0;
  endtask

  function automatic logic [21:0] snap();
    return {cmd_ready, ctrl_zoom_in, ctrl_zoom_out, ctrl_return, ctrl_alg_select,
            sched_busy, fifo_count, done_count, err_flags};
  endfunction

  initial begin
    internal_power_on_reset = 1'b1;
    sw_flush = 0; cmd_valid = 0; cmd_code = 0; cmd_alg = 0;
    ctrl_busy = 0; ctrl_done = 0; ctrl_invalid_zoom = 0;
    repeat (3) tick();
    internal_power_on_reset = 1'b0;
    tick();
    chk("reset_state", 32'(snap()), 32'(RESET_SNAP));

    // Single ZOOM_IN with a normal busy/done handshake
    push(3'd1, 2'd0);
    chk("zin_count", fifo_count, 1);
    chk("zin_early", ctrl_zoom_in, 0);
    tick();
    chk("zin_pulse", ctrl_zoom_in, 1);
    tick();
    chk("zin_width", ctrl_zoom_in, 0);
    ctrl_busy = 1'b1;
    repeat (50) tick();
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0; ctrl_busy = 1'b0;
    chk("zin_done", done_count, 1);
    chk("zin_idle", sched_busy, 0);
    chk("zin_npulse", n_zin, 1);

    // SET_ALG then ZOOM_OUT back-to-back; SET_ALG queued during WAIT_DONE
    push(3'd4, 2'd2);
    push(3'd2, 2'd0);
    tick();
    chk("alg_set", ctrl_alg_select, 2);
    chk("alg_done", done_count, 2);
    chk("alg_zout_early", ctrl_zoom_out, 0);
    tick();
    chk("alg_zout_pulse", ctrl_zoom_out, 1);
    tick();
    ctrl_busy = 1'b1;
    tick();
    push(3'd4, 2'd1);
    repeat (8) tick();
    chk("alg_hold", ctrl_alg_select, 2);
    chk("alg_queued", fifo_count, 1);
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0; ctrl_busy = 1'b0;
    chk("alg_hold_done", ctrl_alg_select, 2);
    chk("alg_done2", done_count, 3);
    tick();
    tick();
    chk("alg_new", ctrl_alg_select, 1);
    chk("alg_done3", done_count, 4);

    // Six ZOOM_IN with a stalled controller: overflow and ack timeouts
    z0 = n_zin;
    for (int i = 0; i < 6; i++) push(3'd1, 2'd0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_ready", cmd_ready, 0);
    chk("ovf_flag", err_flags, 4'b0001);
    repeat (12) tick();
    chk("ack_pre", err_flags, 4'b0001);
    tick();
    chk("ack_flag", err_flags, 4'b0101);
    chk("ack_nopulse", ctrl_zoom_in, 0);
    tick();
    chk("ack_next", ctrl_zoom_in, 1);
    for (int i = 0; i < 200 && sched_busy; i++) tick();
    chk("ovf_drain", sched_busy, 0);
    chk("ovf_issued", n_zin - z0, 5);
    chk("ovf_flags_end", err_flags, 4'b0101);
    chk("ovf_done_same", done_count, 4);

    sw_flush = 1'b1;
    tick();
    sw_flush = 1'b0;
    chk("flush_err", err_flags, 0);
    chk("flush_done", done_count, 0);
    chk("flush_alg", ctrl_alg_select, 1);

    // Invalid zoom: rising edge mid WAIT_ACK, then level already high on first cycle
    push(3'd2, 2'd0);
    tick();
    chk("inv_a_pulse", ctrl_zoom_out, 1);
    tick();
    tick();
    ctrl_invalid_zoom = 1'b1;
    tick();
    chk("inv_a_idle", sched_busy, 0);
    ctrl_invalid_zoom = 1'b0;
    tick();
    ctrl_invalid_zoom = 1'b1;
    push(3'd2, 2'd0);
    tick();
    tick();
    tick();
    chk("inv_b_idle", sched_busy, 0);
    ctrl_invalid_zoom = 1'b0;
    repeat (20) tick();
    chk("inv_err", err_flags, 0);
    chk("inv_done", done_count, 0);

    // Illegal code and NOP
    push(3'd6, 2'd0);
    chk("ill_flag", err_flags, 4'b0010);
    push(3'd0, 2'd0);
    chk("nop_count", fifo_count, 0);
    chk("nop_idle", sched_busy, 0);
    chk("nop_flags", err_flags, 4'b0010);

    // Three commands then flush mid WAIT_ACK
    for (int i = 0; i < 3; i++) push(3'd1, 2'd0);
    chk("fl_pre_count", fifo_count, 2);
    sw_flush = 1'b1; cmd_valid = 1'b1; cmd_code = 3'd3;
    tick();
    sw_flush = 1'b0; cmd_valid = 1'b0; cmd_code = 3'd0;
    chk("fl_count", fifo_count, 0);
    chk("fl_err", err_flags, 0);
    chk("fl_idle", sched_busy, 0);
    z0 = n_zin;
    repeat (40) tick();
    chk("fl_nopulse", n_zin - z0, 0);
    chk("fl_still_idle", sched_busy, 0);

    // Asynchronous reset while in WAIT_DONE
    push(3'd1, 2'd0);
    tick();
    tick();
    ctrl_busy = 1'b1;
    repeat (6) tick();
    chk("rst_pre_busy", sched_busy, 1);
    #5;
    internal_power_on_reset = 1'b1;
    #1;
    chk("rst_async", 32'(snap()), 32'(RESET_SNAP));
    ctrl_busy = 1'b0;
    tick();
    internal_power_on_reset = 1'b0;
    tick();
    chk("rst_after", 32'(snap()), 32'(RESET_SNAP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
